// File: rtl/bus_pkg.sv
// bus: shared arbiter state type and default grant timeout
package bus;
  typedef enum logic {IDLE, OWNED} arb_state_e;
  localparam int ARB_TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search starting just after last_i, with wrap
module rr_pick #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         valid_o,
  output logic [W-1:0] win_o
);
  logic [W-1:0] w_k;
  always_comb begin
    valid_o = |req_i;
    win_o = '0;
    w_k = '0;
    // walk offsets from farthest to nearest so the nearest requester wins
    for (int i = N; i >= 1; i--) begin
      w_k = W'((int'(last_i) + i) % N);
      if (req_i[w_k]) win_o = w_k;
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with burst lock and grant timeout
module bus_arbiter
  import bus::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  localparam int IW = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [NUM_MASTERS-1:0] lock_i,
  input  logic                   ack_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IW-1:0]          gnt_idx_o,
  output logic                   busy_o,
  output logic                   timeout_o
);
  arb_state_e r_state, w_next;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [IW-1:0] r_idx, r_last, w_win;
  logic [15:0] r_cnt;
  logic r_busy, r_to, w_valid, w_ack_rel, w_abort, w_tmo, w_rel;
  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i  (req_i),
    .last_i (r_last),
    .valid_o(w_valid),
    .win_o  (w_win)
  );
  // ack beats both abort and timeout; abort beats timeout
  always_comb begin
    w_ack_rel = ack_i & ~lock_i[r_idx];
    w_abort = ~ack_i & ~req_i[r_idx];
    w_tmo = ~ack_i & req_i[r_idx] & (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    w_rel = (r_state == OWNED) & (w_ack_rel | w_abort | w_tmo);
    w_next = (r_state == IDLE) ? (w_valid ? OWNED : IDLE) : (w_rel ? IDLE : OWNED);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_idx <= '0;
      r_last <= IW'(NUM_MASTERS - 1);
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_to <= 1'b0;
    end else begin
      r_state <= w_next;
      r_to <= (r_state == OWNED) & w_tmo;
      if (r_state == IDLE) begin
        if (w_valid) begin
          r_gnt <= NUM_MASTERS'(1) << w_win;
          r_idx <= w_win;
          r_busy <= 1'b1;
        end
        r_cnt <= '0;
      end else if (w_rel) begin
        r_gnt <= '0;
        r_busy <= 1'b0;
        r_last <= r_idx;
        r_cnt <= '0;
      end else begin
        r_cnt <= ack_i ? 16'd0 : r_cnt + 16'd1;
      end
    end
  end
  assign gnt_o = r_gnt;
  assign gnt_idx_o = r_idx;
  assign busy_o = r_busy;
  assign timeout_o = r_to;
endmodule
